pipelined_cselect_adder: RTL
============================

Name: pipelined_cselect_adder

Overview:
- Parametrised, pipelined carry-select adder with a valid/ready stream interface.
- Splits a WIDTH-bit add into BLOCK_WIDTH carry-select blocks and groups BLOCKS_PER_STAGE blocks per pipeline stage. Registers the block carry and skewed operands between stages.
- Throughput: one add per clock. Sits on the datapath between operand staging and the accumulator and MAC units, where the unpipelined adder cannot meet timing at 64+ bits.

Parameters:
- WIDTH, 64, operand and sum width. Must be a multiple of BLOCK_WIDTH.
- BLOCK_WIDTH, 8, width of one carry-select block.
- BLOCKS_PER_STAGE, 2, blocks evaluated combinationally per pipeline stage. WIDTH/BLOCK_WIDTH must be a multiple of it.
- Derived: NBLK = WIDTH/BLOCK_WIDTH; NSTG = NBLK/BLOCKS_PER_STAGE (pipeline latency in cycles).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  synchronous, active-high reset.
- iValid  in  1  operands valid.
- oReady  out  1  block can accept operands this cycle.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- iC  in  1  carry-in.
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts result.
- oS  out  WIDTH  sum.
- oC  out  1  carry-out.
- oV  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clock only, iClk. Reset is synchronous and active-high on iRst; polarity and synchronicity are fixed.
- Reset values: all stage valid bits = 0; oValid = 0; oS = 0; oC = 0; oV = 0. Data registers are also cleared to 0. oReady = 1 in the cycle after reset deasserts.
- Stage k (0..NSTG-1):
  - Computes blocks k*BLOCKS_PER_STAGE .. (k+1)*BLOCKS_PER_STAGE-1.
  - Uses the carry registered by stage k-1; stage 0 uses iC.
  - Each block computes its sum for carry-in 0 and carry-in 1 in parallel, then muxes on the incoming carry.
  - Sum slices already produced are forwarded unchanged.
  - Operand slices not yet consumed are forwarded unchanged. Registers shrink per stage; no full-width operand copies.
- Latency: a transfer accepted on edge t appears on oValid/oS/oC/oV after edge t+NSTG, provided there is no stall.
- Handshake:
  - Input transfer occurs when iValid & oReady. Output transfer occurs when oValid & iReady.
  - Global advance enable: en = iReady | ~oValid. oReady = en (combinational from iReady and oValid).
  - When en = 1, every stage register loads from its predecessor, and stage 0 valid loads iValid.
  - When en = 0, all stage registers hold, including data and valid bits.
  - Bubbles are not compressed: a full stall occurs only when the output holds valid data and downstream is not ready. Simple enable, no skid buffer.
- Output stability: oS/oC/oV are constant while oValid = 1 and iReady = 0.
- Data is don't-care when valid = 0, but registers still load so that reset values are predictable.
- Arithmetic:
  - {oC, oS} = iA + iB + iC, modulo 2^(WIDTH+1).
  - oV = (iA[MSB] == iB[MSB]) & (oS[MSB] != iA[MSB]).
- Boundary cases:
  - NSTG = 1: single register stage. Behaves as a registered adder with latency 1.
  - Full carry ripple across all stages, e.g. all-ones + 1: must be correct.
  - Reset mid-operation: in-flight results are discarded and oValid drops the cycle after reset.
  - Reset asserted together with iValid: the input is not captured.

Optional Feature:
- Macro PIPE_ADDER_SUB_EN.
- Defined:
  - Adds input port iSub (1 bit), captured with the operands and carried through the pipeline.
  - When iSub = 1, the stage-0 effective operation is iA + ~iB + 1. iC is ignored and replaced by 1.
  - oC is the no-borrow flag (1 = iA >= iB unsigned).
  - oV uses the inverted-B MSB.
- Undefined: no iSub port; add only; logic is identical to the base behaviour above.

Decomposition:
- Package adder_pkg:
  - Function for the NSTG/NBLK derivation.
  - Parameter-legality checks (divisibility) raised as elaboration errors.
  - Localparam for the default BLOCK_WIDTH shared with other adders.
- One sub-module, cselect_stage: combinational; BLOCKS_PER_STAGE carry-select blocks, carry-in to carry-out. Instantiated NSTG times in a generate loop.
- The top module holds all registers and the handshake logic.

Test Plan:
- Default params, reset then a single transfer iA=0xFFFFFFFFFFFFFFFF, iB=0, iC=1 -> oValid after exactly 4 cycles; oS=0, oC=1, oV=0.
- Back-to-back stream of 100 random operand sets, iReady=1 constant -> one result per cycle, in order, each matching iA+iB+iC.
- Stream with iReady toggling 1,0,0,1 -> oReady follows en; no result is lost or duplicated; oS is held stable during stalls.
- Signed overflow: iA=0x7FFFFFFFFFFFFFFF, iB=1, iC=0 -> oS=0x8000000000000000, oV=1, oC=0.
- Reset asserted with 3 results in flight -> oValid=0 on the next cycle; no stale result emerges afterwards.
- With PIPE_ADDER_SUB_EN, iSub=1, iA=5, iB=7 -> oS=0xFFFFFFFFFFFFFFFE, oC=0. Rerun with WIDTH=32, BLOCK_WIDTH=8, BLOCKS_PER_STAGE=4 -> latency 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Purpose : shared constants and parameter helpers for the pipelined adders.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: default carry-select block width, block/stage count derivation,
// and a legality predicate the adders use to reject bad parameter sets at
// elaboration time.
package adder_pkg;

  // Block width shared by every carry-select adder in the datapath.
  localparam int DEFAULT_BLOCK_WIDTH = 8;

  function automatic int calc_nblk(input int width, input int block_width);
    return width / block_width;
  endfunction

  // Number of register stages, which is also the pipeline latency in cycles.
  function automatic int calc_nstg(input int width, input int block_width,
                                   input int blocks_per_stage);
    return calc_nblk(width, block_width) / blocks_per_stage;
  endfunction

  function automatic bit params_legal(input int width, input int block_width,
                                      input int blocks_per_stage);
    if (width <= 0 || block_width <= 0 || blocks_per_stage <= 0) return 1'b0;
    if ((width % block_width) != 0) return 1'b0;
    return (calc_nblk(width, block_width) % blocks_per_stage) == 0;
  endfunction

endpackage

// File: rtl/cselect_stage.sv
// Purpose : combinational carry-select slice of NUM_BLOCKS blocks.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the enclosing pipeline owns all handshaking.
//
// Ports: a, b  - operand slices; c_in - carry into the lowest block;
//        sum   - slice sum;      c_out - carry out of the highest block.
module cselect_stage
  import adder_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH,
  parameter int NUM_BLOCKS  = 2
) (
  input  logic [NUM_BLOCKS*BLOCK_WIDTH-1:0] a,
  input  logic [NUM_BLOCKS*BLOCK_WIDTH-1:0] b,
  input  logic                              c_in,
  output logic [NUM_BLOCKS*BLOCK_WIDTH-1:0] sum,
  output logic                              c_out
);

  // Both candidate results of every block are formed in parallel; only the
  // select chain below depends on the carry.
  logic [BLOCK_WIDTH:0] r0 [NUM_BLOCKS];
  logic [BLOCK_WIDTH:0] r1 [NUM_BLOCKS];
  logic                 carry;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    logic [BLOCK_WIDTH-1:0] a_blk;
    logic [BLOCK_WIDTH-1:0] b_blk;
    assign a_blk = a[i*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign b_blk = b[i*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign r0[i] = {1'b0, a_blk} + {1'b0, b_blk};
    assign r1[i] = {1'b0, a_blk} + {1'b0, b_blk} + {{BLOCK_WIDTH{1'b0}}, 1'b1};
  end

  always_comb begin
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      sum[i*BLOCK_WIDTH +: BLOCK_WIDTH] = carry ? r1[i][BLOCK_WIDTH-1:0]
                                                : r0[i][BLOCK_WIDTH-1:0];
      carry = carry ? r1[i][BLOCK_WIDTH] : r0[i][BLOCK_WIDTH];
    end
    c_out = carry;
  end

endmodule

// File: rtl/pipelined_cselect_adder.sv
// Purpose : WIDTH-bit pipelined carry-select adder with valid/ready stream.
// Latency : NSTG cycles from the input handshake cycle to oValid.
// Backpr. : single global enable; whole pipe holds while oValid & ~iReady.
//
// Ports: iClk/iRst (sync, active-high); iValid/oReady + iA/iB/iC operands;
//        oValid/iReady + oS sum, oC carry-out, oV signed overflow.
// Option: PIPE_ADDER_SUB_EN adds iSub; when set the op is iA + ~iB + 1, iC is
//         ignored and oC becomes the no-borrow flag (iA >= iB unsigned).
//
// Stage k owns the sum bits produced so far plus only the operand bits not
// yet consumed, so the registers narrow as the add progresses.
module pipelined_cselect_adder
  import adder_pkg::*;
#(
  parameter int WIDTH            = 64,
  parameter int BLOCK_WIDTH      = DEFAULT_BLOCK_WIDTH,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             iSub,
`endif
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oV
);

  localparam int NSTG = calc_nstg(WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE);
  localparam int SW   = BLOCK_WIDTH * BLOCKS_PER_STAGE;  // bits per stage

  if (!params_legal(WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE)) begin : g_bad_params
    $error("pipelined_cselect_adder: WIDTH/BLOCK_WIDTH/BLOCKS_PER_STAGE not divisible");
  end

  logic en;
  assign en     = iReady | ~oValid;
  assign oReady = en;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int IW = WIDTH - k*SW;  // operand bits still unconsumed here

    logic [IW-1:0]       a_in;
    logic [IW-1:0]       b_in;
    logic                c_in;
    logic                v_in;
    logic                sub_in;
    logic [SW-1:0]       b_eff;
    logic [SW-1:0]       s_blk;
    logic                c_blk;
    logic [(k+1)*SW-1:0] sum_nx;
    logic [(k+1)*SW-1:0] sum_q, sum_d;
    logic                c_q, c_d;
    logic                vld_q, vld_d;

    if (k == 0) begin : g_src
      assign a_in = iA;
      assign b_in = iB;
      assign v_in = iValid;
`ifdef PIPE_ADDER_SUB_EN
      assign sub_in = iSub;
`else
      assign sub_in = 1'b0;
`endif
      // Subtraction forces the +1 of the two's complement in as carry-in.
      assign c_in   = iC | sub_in;
      assign sum_nx = s_blk;
    end else begin : g_src
      assign a_in   = g_stg[k-1].g_fwd.a_q;
      assign b_in   = g_stg[k-1].g_fwd.b_q;
      assign v_in   = g_stg[k-1].vld_q;
      assign sub_in = g_stg[k-1].g_fwd.sub_q;
      assign c_in   = g_stg[k-1].c_q;
      assign sum_nx = {s_blk, g_stg[k-1].sum_q};
    end

    // B is kept raw in the pipe and inverted slice by slice as it is consumed.
    assign b_eff = b_in[SW-1:0] ^ {SW{sub_in}};

    cselect_stage #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .NUM_BLOCKS  (BLOCKS_PER_STAGE)
    ) u_cselect (
      .a     (a_in[SW-1:0]),
      .b     (b_eff),
      .c_in  (c_in),
      .sum   (s_blk),
      .c_out (c_blk)
    );

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      sum_d = sum_q;
      if (en) begin
        vld_d = v_in;
        c_d   = c_blk;
        sum_d = sum_nx;
      end
    end

    always_ff @(posedge iClk) begin
      if (iRst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    if (k < NSTG-1) begin : g_fwd
      localparam int FW = IW - SW;
      logic [FW-1:0] a_q, a_d;
      logic [FW-1:0] b_q, b_d;
      logic          sub_q, sub_d;

      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sub_d = sub_q;
        if (en) begin
          a_d   = a_in[IW-1:SW];
          b_d   = b_in[IW-1:SW];
          sub_d = sub_in;
        end
      end

      always_ff @(posedge iClk) begin
        if (iRst) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_d;
        end
      end
    end else begin : g_ovf
      // Overflow: same-sign operands (B as actually added) giving a
      // different-sign result; equivalent to carry-in XOR carry-out at the MSB.
      logic v_nx;
      logic v_q, v_d;
      assign v_nx = (a_in[SW-1] == b_eff[SW-1]) & (s_blk[SW-1] != a_in[SW-1]);

      always_comb begin
        v_d = v_q;
        if (en) v_d = v_nx;
      end

      always_ff @(posedge iClk) begin
        if (iRst) v_q <= 1'b0;
        else      v_q <= v_d;
      end
    end
  end

  assign oValid = g_stg[NSTG-1].vld_q;
  assign oS     = g_stg[NSTG-1].sum_q;
  assign oC     = g_stg[NSTG-1].c_q;
  assign oV     = g_stg[NSTG-1].g_ovf.v_q;

endmodule
